// File: rtl/mram_host_pkg.sv
// Shared op codes, FSM encoding and default widths for the MRAM serial host.
package mram_host_pkg;

  localparam int unsigned ADDR_W_DEF        = 20;
  localparam int unsigned DATA_W_DEF        = 16;
  localparam int unsigned ACCESS_CYCLES_DEF = 4;
  localparam int unsigned TURN_CYCLES_DEF   = 1;
  localparam int unsigned OP_W              = 3;

  localparam logic [OP_W-1:0] OP_IDLE  = 3'b000;
  localparam logic [OP_W-1:0] OP_WR    = 3'b001;
  localparam logic [OP_W-1:0] OP_RD    = 3'b010;
  localparam logic [OP_W-1:0] OP_RD_LO = 3'b011;
  localparam logic [OP_W-1:0] OP_RD_HI = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_ACCESS,
    ST_TURN,
    ST_CAPTURE,
    ST_RESP
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_WR) || (op == OP_RD) || (op == OP_RD_LO) || (op == OP_RD_HI);
  endfunction

endpackage

// File: rtl/mram_host_shifter.sv
// Multi-lane MSB-first shift register: parallel load, shift-out and shift-in.
module mram_host_shifter #(
  parameter int unsigned W     = 16,
  parameter int unsigned LANES = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ld,
  input  logic                      shift_en,
  input  logic [LANES-1:0][W-1:0]   par_in,
  input  logic [LANES-1:0]          ser_in,
  output logic [LANES-1:0][W-1:0]   par_out,
  output logic [LANES-1:0]          ser_out
);

  logic [LANES-1:0][W-1:0] nxt;

  // Load wins over shift; each lane shifts toward its MSB.
  always_comb begin
    nxt = par_out;
    if (ld) begin
      nxt = par_in;
    end else if (shift_en) begin
      for (int l = 0; l < int'(LANES); l++) begin
        nxt[l] = {par_out[l][W-2:0], ser_in[l]};
      end
    end
  end

  always_comb begin
    ser_out = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      ser_out[l] = par_out[l][W-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) par_out <= '0;
    else      par_out <= nxt;
  end

endmodule

// File: rtl/mram_serial_host.sv
// Serial-link master for the MRAM bridge: parallel command in, fixed-timing serial transaction out.
// Optional transfer counters are built when MRAM_HOST_PERF_EN is defined.
module mram_serial_host
  import mram_host_pkg::*;
#(
  parameter int unsigned ADDR_W        = ADDR_W_DEF,
  parameter int unsigned DATA_W        = DATA_W_DEF,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEF,
  parameter int unsigned TURN_CYCLES   = TURN_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              ser_data_o,
  output logic              ser_addr_o,
  output logic [OP_W-1:0]   rw_sel_o,
  input  logic              ser_data_i,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              wr_done,
  output logic              busy
`ifdef MRAM_HOST_PERF_EN
  ,
  output logic [15:0]       wr_count,
  output logic [15:0]       rd_count
`endif
);

  localparam int unsigned MAX_AD  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int unsigned MAX_AT  = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_AD > MAX_AT) ? MAX_AD : MAX_AT;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              cmd_ready_d, busy_d, wr_done_d, rsp_valid_d;
  logic [OP_W-1:0]   rw_sel_d;
  logic              out_ld, out_sh, cap_ld, cap_sh, cap_bit;

  logic [1:0][ADDR_W-1:0] out_load, unused_out_par;
  logic [1:0]             out_ser;
  logic [0:0][DATA_W-1:0] cap_q;
  logic [0:0]             unused_cap_ser;

  // Lane 1 carries the address, lane 0 the zero-padded write data.
  assign out_load[1] = cmd_addr;
  assign out_load[0] = ADDR_W'((cmd_op == OP_WR) ? cmd_wdata : DATA_W'(0));
  assign ser_addr_o  = out_ser[1];
  assign ser_data_o  = out_ser[0];
  assign rsp_rdata   = cap_q[0];

  mram_host_shifter #(.W(ADDR_W), .LANES(2)) u_out_shift (
    .clk      (clk),
    .rst      (rst),
    .ld       (out_ld),
    .shift_en (out_sh),
    .par_in   (out_load),
    .ser_in   (2'b00),
    .par_out  (unused_out_par),
    .ser_out  (out_ser)
  );

  mram_host_shifter #(.W(DATA_W), .LANES(1)) u_cap_shift (
    .clk      (clk),
    .rst      (rst),
    .ld       (cap_ld),
    .shift_en (cap_sh),
    .par_in   ('0),
    .ser_in   (cap_bit),
    .par_out  (cap_q),
    .ser_out  (unused_cap_ser)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rw_sel_o  <= OP_IDLE;
      wr_done   <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      cmd_ready <= cmd_ready_d;
      busy      <= busy_d;
      rw_sel_o  <= rw_sel_d;
      wr_done   <= wr_done_d;
      rsp_valid <= rsp_valid_d;
    end
  end

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    out_ld    = 1'b0;
    out_sh    = 1'b0;
    cap_ld    = 1'b0;
    cap_sh    = 1'b0;
    cap_bit   = 1'b0;
    wr_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Illegal ops are accepted here but simply never leave IDLE.
        if (cmd_valid && cmd_ready && op_legal(cmd_op)) begin
          op_d    = cmd_op;
          out_ld  = 1'b1;
          cap_ld  = 1'b1;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        out_sh = 1'b1;
        if (cnt_q == CNT_W'(ADDR_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_ACCESS;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACCESS: begin
        if (cnt_q == CNT_W'(ACCESS_CYCLES - 1)) begin
          cnt_d = '0;
          if (op_q == OP_WR) begin
            state_d   = ST_IDLE;
            wr_done_d = 1'b1;
          end else begin
            state_d = (TURN_CYCLES != 0) ? ST_TURN : ST_CAPTURE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt_q == CNT_W'(TURN_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        // Byte reads zero the unwanted half as it streams in.
        cap_sh = 1'b1;
        case (op_q)
          OP_RD_LO: cap_bit = ser_data_i & (cnt_q >= CNT_W'(DATA_W - 8));
          OP_RD_HI: cap_bit = ser_data_i & (cnt_q <  CNT_W'(DATA_W - 8));
          default:  cap_bit = ser_data_i;
        endcase
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    rw_sel_d    = (state_d == ST_ACCESS) ? op_q : OP_IDLE;
  end

`ifdef MRAM_HOST_PERF_EN
  // Completed-transfer counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
      rd_count <= '0;
    end else begin
      if (wr_done_d)              wr_count <= wr_count + 16'd1;
      if (rsp_valid && rsp_ready) rd_count <= rd_count + 16'd1;
    end
  end
`else
  // Transfer counters not built in this configuration.
`endif

endmodule

// File: tb/tb_mram_serial_host.sv
// Self-checking bench for mram_serial_host: transaction-level model, per-cycle compare, directed vectors.
module tb_mram_serial_host;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int ACC    = 4;
  localparam int TURN   = 1;
  localparam int CAP_T  = 1 + ADDR_W + ACC + TURN;
  localparam int RESP_T = CAP_T + DATA_W;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'b000;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic        ser_data_o, ser_addr_o;
  logic [2:0]  rw_sel_o;
  logic        ser_data_i = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_rdata;
  logic        wr_done, busy;
`ifdef MRAM_HOST_PERF_EN
  logic [15:0] wr_count, rd_count;
  int          m_wr_cnt, m_rd_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cyc = 0;
  logic [15:0] br_word = '0;

  // Transaction-level model state.
  logic        m_active, m_done;
  int          m_t;
  logic [2:0]  m_op;
  logic [19:0] m_addr;
  logic [15:0] m_wdata, m_word;

  // Per-transaction recording of DUT outputs, indexed by cycle since accept.
  logic        col_addr [0:63];
  logic        col_data [0:63];
  logic [2:0]  col_rw   [0:63];
  logic        col_wd   [0:63];
  logic        col_rv   [0:63];
  logic        col_cr   [0:63];
  logic [15:0] col_rd   [0:63];

  mram_serial_host dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .ser_data_o (ser_data_o),
    .ser_addr_o (ser_addr_o),
    .rw_sel_o   (rw_sel_o),
    .ser_data_i (ser_data_i),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .wr_done    (wr_done),
`ifdef MRAM_HOST_PERF_EN
    .busy       (busy),
    .wr_count   (wr_count),
    .rd_count   (rd_count)
`else
    .busy       (busy)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic legal(input logic [2:0] op);
    return op inside {3'b001, 3'b010, 3'b011, 3'b100};
  endfunction

  function automatic logic [15:0] masked(input logic [2:0] op, input logic [15:0] w);
    case (op)
      3'b011:  return {8'h00, w[7:0]};
      3'b100:  return {w[15:8], 8'h00};
      default: return w;
    endcase
  endfunction

  // Model: a transaction runs cycles 1..24 (write) or 1..42 plus any rsp wait (read).
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
      m_op     <= 3'b000;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_word   <= '0;
`ifdef MRAM_HOST_PERF_EN
      m_wr_cnt <= 0;
      m_rd_cnt <= 0;
`endif
    end else begin
      m_done <= 1'b0;
      if (!m_active) begin
        if (cmd_valid && legal(cmd_op)) begin
          m_active <= 1'b1;
          m_t      <= 1;
          m_op     <= cmd_op;
          m_addr   <= cmd_addr;
          m_wdata  <= cmd_wdata;
          m_word   <= br_word;
        end
      end else if (m_op == 3'b001 && m_t == ADDR_W + ACC) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
`ifdef MRAM_HOST_PERF_EN
        m_wr_cnt <= (m_wr_cnt + 1) % 65536;
`endif
      end else if (m_op != 3'b001 && m_t == RESP_T) begin
        if (rsp_ready) begin
          m_active <= 1'b0;
`ifdef MRAM_HOST_PERF_EN
          m_rd_cnt <= (m_rd_cnt + 1) % 65536;
`endif
        end
      end else begin
        m_t <= m_t + 1;
      end
    end
  end

  // Bridge model: returns the word MSB first during the capture window, junk elsewhere.
  always @(posedge clk) begin
    #1;
    if (m_active && m_op != 3'b001 && m_t >= CAP_T && m_t < CAP_T + DATA_W)
      ser_data_i = m_word[DATA_W-1-(m_t-CAP_T)];
    else
      ser_data_i = 1'($urandom);
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    logic       e_addr, e_data, e_rv;
    logic [2:0] e_rw;
    e_addr = (m_active && m_t >= 1 && m_t <= ADDR_W) ? m_addr[ADDR_W-m_t] : 1'b0;
    e_data = (m_active && m_op == 3'b001 && m_t > ADDR_W - DATA_W && m_t <= ADDR_W)
             ? m_wdata[ADDR_W-m_t] : 1'b0;
    e_rw   = (m_active && m_t > ADDR_W && m_t <= ADDR_W + ACC) ? m_op : 3'b000;
    e_rv   = m_active && m_op != 3'b001 && m_t == RESP_T;
    chk("cmd_ready", cmd_ready, !m_active);
    chk("busy", busy, m_active);
    chk("ser_addr_o", ser_addr_o, e_addr);
    chk("ser_data_o", ser_data_o, e_data);
    chk("rw_sel_o", rw_sel_o, e_rw);
    chk("wr_done", wr_done, m_done);
    chk("rsp_valid", rsp_valid, e_rv);
    if (!rst)      chk("rsp_rdata_rst", rsp_rdata, 16'h0000);
    else if (e_rv) chk("rsp_rdata", rsp_rdata, masked(m_op, m_word));
`ifdef MRAM_HOST_PERF_EN
    chk("wr_count", wr_count, m_wr_cnt);
    chk("rd_count", rd_count, m_rd_cnt);
`endif
  end

  always @(negedge clk) begin
    int rel;
    rel = cyc - acc_cyc;
    if (rel >= 0 && rel < 64) begin
      col_addr[rel] = ser_addr_o;
      col_data[rel] = ser_data_o;
      col_rw[rel]   = rw_sel_o;
      col_wd[rel]   = wr_done;
      col_rv[rel]   = rsp_valid;
      col_cr[rel]   = cmd_ready;
      col_rd[rel]   = rsp_rdata;
    end
  end

  function automatic logic [19:0] addr_bits();
    logic [19:0] v = '0;
    for (int t = 1; t <= ADDR_W; t++) v = {v[18:0], col_addr[t]};
    return v;
  endfunction

  function automatic logic [19:0] data_bits();
    logic [19:0] v = '0;
    for (int t = 1; t <= ADDR_W; t++) v = {v[18:0], col_data[t]};
    return v;
  endfunction

  function automatic int rv_count();
    int n = 0;
    for (int t = 0; t < 64; t++) if (col_rv[t]) n++;
    return n;
  endfunction

  // Called at posedge+1 while the model is idle; that cycle becomes cycle 0.
  task automatic issue(input logic [2:0] op, input logic [19:0] addr, input logic [15:0] wd);
    for (int i = 0; i < 64; i++) begin
      col_addr[i] = 1'b0; col_data[i] = 1'b0; col_rw[i] = 3'b000; col_wd[i] = 1'b0;
      col_rv[i] = 1'b0; col_cr[i] = 1'b0; col_rd[i] = 16'h0000;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    acc_cyc   = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_addr  = 20'($urandom);
    cmd_wdata = 16'($urandom);
  endtask

  task automatic wait_rel(input int n);
    int g = 0;
    while (cyc - acc_cyc < n) begin
      @(posedge clk); #1;
      g++;
      if (g > 500) begin
        total++; bad++;
        $display("FAIL wait_rel: got timeout want cycle %0d", n);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int g = 0;
    while (m_active) begin
      @(posedge clk); #1;
      g++;
      if (g > 500) begin
        total++; bad++;
        $display("FAIL wait_idle: got timeout want idle");
        return;
      end
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rw_sel"}, rw_sel_o, 3'b000);
    chk({tag, "_ser_addr"}, ser_addr_o, 1'b0);
    chk({tag, "_ser_data"}, ser_data_o, 1'b0);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 16'h0000);
    chk({tag, "_wr_done"}, wr_done, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    #1 rst = 1'b0;
    #1 chk_reset_vals(tag);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    int w_acc;
    int n_ok;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    rst = 1'b1;
    @(posedge clk); #1;

    // Illegal op: dropped with no bus activity.
    issue(3'b111, 20'hFFFFF, 16'hFFFF);
    chk("illegal_busy_c1", busy, 1'b0);
    chk("illegal_ready_c1", cmd_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back write ABCDE/1234 then read word from 00010.
    br_word = 16'hBEEF;
    issue(3'b001, 20'hABCDE, 16'h1234);
    w_acc = acc_cyc;
    wait_idle();
    chk("wr_addr_bits", addr_bits(), 20'hABCDE);
    chk("wr_data_bits", data_bits(), 20'h01234);
    chk("wr_rw_c20", col_rw[20], 3'b000);
    chk("wr_rw_c21", col_rw[21], 3'b001);
    chk("wr_rw_c24", col_rw[24], 3'b001);
    chk("wr_done_c24", col_wd[24], 1'b0);
    chk("wr_done_c25", wr_done, 1'b1);
    chk("wr_ready_c25", cmd_ready, 1'b1);
    issue(3'b010, 20'h00010, 16'h5555);
    chk("b2b_accept_gap", acc_cyc - w_acc, 25);
    wait_idle();
    chk("rd_rw_c21", col_rw[21], 3'b010);
    chk("rd_rw_c25", col_rw[25], 3'b000);
    chk("rd_valid_c41", col_rv[41], 1'b0);
    chk("rd_valid_c42", col_rv[42], 1'b1);
    chk("rd_rdata_c42", col_rd[42], 16'hBEEF);
    chk("rd_data_quiet", data_bits(), 20'h00000);
`ifdef MRAM_HOST_PERF_EN
    chk("perf_wr_count", wr_count, 16'd1);
    chk("perf_rd_count", rd_count, 16'd1);
`endif

    // Byte reads of A55A.
    br_word = 16'hA55A;
    issue(3'b011, 20'h00400, 16'h0000);
    wait_idle();
    chk("rdlo_rdata", col_rd[42], 16'h005A);
    issue(3'b100, 20'hFFFFF, 16'hFFFF);
    wait_idle();
    chk("rdhi_rdata", col_rd[42], 16'hA500);

    // Response back-pressure: rsp_ready low for 10 cycles after rsp_valid.
    br_word = 16'h3C96;
    rsp_ready = 1'b0;
    issue(3'b010, 20'h7F00F, 16'h0000);
    wait_rel(RESP_T + 10);
    rsp_ready = 1'b1;
    wait_rel(RESP_T + 12);
    n_ok = 0;
    for (int t = RESP_T; t <= RESP_T + 10; t++)
      if (col_rv[t] && col_rd[t] == 16'h3C96 && !col_cr[t]) n_ok++;
    chk("hold_stable_cycles", n_ok, 11);
    chk("hold_ready_c53", col_cr[53], 1'b1);
    chk("hold_valid_c53", col_rv[53], 1'b0);

    // Reset in SHIFT cycle 10, then a fresh write.
    issue(3'b001, 20'h5A5A5, 16'hFFFF);
    wait_rel(10);
    pulse_reset("rst_shift");
    issue(3'b001, 20'h12345, 16'hC3A5);
    wait_rel(27);
    chk("post_rst1_addr", addr_bits(), 20'h12345);
    chk("post_rst1_data", data_bits(), 20'h0C3A5);
    chk("post_rst1_done_c24", col_wd[24], 1'b0);
    chk("post_rst1_done_c25", col_wd[25], 1'b1);
    chk("post_rst1_no_rsp", rv_count(), 0);

    // Reset in transaction cycle 30 (mid-capture) of a read, then a fresh write.
    br_word = 16'hFFFF;
    issue(3'b010, 20'h0000F, 16'h0000);
    wait_rel(30);
    pulse_reset("rst_capture");
    issue(3'b001, 20'h80001, 16'h8001);
    wait_rel(45);
    chk("post_rst2_done_c25", col_wd[25], 1'b1);
    chk("post_rst2_rw_c21", col_rw[21], 3'b001);
    chk("post_rst2_no_rsp", rv_count(), 0);
    chk("post_rst2_rdata", rsp_rdata, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
